// File: rtl/bim_update_ctrl.sv
// Bimodal predictor table controller: init sweep, fetch lookup and
// 2-bit saturating counter updates with back-to-back forwarding.
module bim_update_ctrl #(
    parameter int         PC_LSB   = 2,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid_i,
    input  logic [31:0] pc_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [1:0]  pred_cnt_o,
    output logic        ready_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [1:0]  upd_cnt_i,
    output logic [9:0]  ram_a_o,
    output logic [1:0]  ram_d_o,
    output logic        ram_we_o,
    output logic [9:0]  ram_dpra_o,
    input  logic [1:0]  ram_bits_i
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] init_idx;
    logic [9:0] upd_idx;
    logic       wr_vld;
    logic [9:0] wr_idx;
    logic [1:0] wr_cnt;
    logic [1:0] base;
    logic [1:0] cnt_new;
    logic       unused_bits;

    assign unused_bits = ^{pc_i, upd_pc_i};

    assign upd_idx    = upd_pc_i[PC_LSB+9:PC_LSB];
    assign ram_dpra_o = pc_i[PC_LSB+9:PC_LSB];
    assign ready_o    = (state == RUN);

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_idx == 10'd1023) begin
            state_nxt = RUN;
        end
    end

    // Forward the in-flight write so consecutive updates accumulate.
    always_comb begin
        base    = upd_cnt_i;
        cnt_new = 2'b00;
        if (wr_vld && wr_idx == upd_idx) begin
            base = wr_cnt;
        end
        if (upd_taken_i) begin
            cnt_new = (base == 2'b11) ? 2'b11 : base + 2'b01;
        end else begin
            cnt_new = (base == 2'b00) ? 2'b00 : base - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= INIT;
            init_idx     <= 10'd0;
            wr_vld       <= 1'b0;
            wr_idx       <= 10'd0;
            wr_cnt       <= 2'b00;
            pred_valid_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_vld       <= (state == RUN) && upd_valid_i;
            pred_valid_o <= (state == RUN) && pc_valid_i;
            if (state == INIT) begin
                init_idx <= init_idx + 10'd1;
            end
            if (state == RUN && upd_valid_i) begin
                wr_idx <= upd_idx;
                wr_cnt <= cnt_new;
            end
        end
    end

    always_comb begin
        ram_we_o = wr_vld;
        ram_a_o  = wr_idx;
        ram_d_o  = wr_cnt;
        if (state == INIT) begin
            ram_we_o = 1'b1;
            ram_a_o  = init_idx;
            ram_d_o  = INIT_CNT;
        end
    end

    assign pred_taken_o = ram_bits_i[1] & pred_valid_o;
    assign pred_cnt_o   = pred_valid_o ? ram_bits_i : 2'b00;

endmodule

// File: doc/bim_update_ctrl.md
# bim_update_ctrl

Controller that sits directly in front of the 1024-entry bimodal counter RAM and drives both its ports. It sweeps the table to a known value after reset, indexes the RAM read port from fetch PCs and returns the prediction one cycle later. It also turns branch-resolution events into 2-bit saturating counter writes, with forwarding between back-to-back updates to the same entry.

## Interface
Parameters:
- PC_LSB, 2, lowest PC bit used for the index; index = pc[PC_LSB+9:PC_LSB]
- INIT_CNT, 2'b01, counter value written to every entry during init (weakly not-taken)

Ports:
- clk  in  1  single clock; the RAM's clk and qdpo_clk are both tied to it
- rst  in  1  synchronous, active-low reset
- pc_valid_i  in  1  fetch lookup request
- pc_i  in  32  fetch PC
- pred_valid_o  out  1  prediction valid (registered)
- pred_taken_o  out  1  predicted direction = ram_bits_i[1] & pred_valid_o
- pred_cnt_o  out  2  raw counter; 0 when pred_valid_o = 0
- ready_o  out  1  init done; lookups and updates accepted
- upd_valid_i  in  1  branch resolved
- upd_pc_i  in  32  PC of the resolved branch
- upd_taken_i  in  1  actual outcome
- upd_cnt_i  in  2  counter snapshot returned with that branch's prediction
- ram_a_o  out  10  RAM write address
- ram_d_o  out  2  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_dpra_o  out  10  RAM read address (combinational from pc_i)
- ram_bits_i  in  2  RAM registered read data

## Operation
- States: INIT and RUN. Reset forces INIT with init_idx = 0.
- INIT:
  - Every cycle: ram_we_o = 1, ram_a_o = init_idx, ram_d_o = INIT_CNT, then init_idx increments.
  - When init_idx = 1023 is written, the state moves to RUN and ready_o = 1 from the next cycle.
  - pc_valid_i and upd_valid_i are ignored and dropped.
- RUN, lookup: ram_dpra_o = pc_i index whenever in RUN. pred_valid_o <= pc_valid_i.
- RUN, update: when upd_valid_i, the block computes base and new, then registers the write (wr_vld, wr_idx, wr_cnt):
  - base = wr_cnt if (wr_vld and wr_idx == upd index), else upd_cnt_i.
  - new = sat_inc(base) if taken, else sat_dec(base).
  - Saturation: 3 stays 3 when taken; 0 stays 0 when not taken.
- The write registers drive ram_we_o = wr_vld, ram_a_o = wr_idx, ram_d_o = wr_cnt.
- With no update, wr_vld clears the next cycle.
- Same-index read/write: the RAM returns the write data when dpra == a during a write.
- Reset mid-operation: any state returns to INIT next cycle, init_idx = 0, and a pending write is dropped.

## Timing
- Reset values: pred_valid_o = 0, pred_taken_o = 0, pred_cnt_o = 0, ready_o = 0, wr_vld = 0, init_idx = 0.
  - ram_we_o = 1 from the first cycle after reset, because INIT begins writing.
- Init takes exactly 1024 cycles. ready_o rises 1024 cycles after the reset-release edge.
- Lookup latency is 1 cycle. A PC presented in cycle N produces prediction outputs valid in cycle N+1. One lookup is accepted per cycle, with no backpressure.
- Update latency is 1 cycle. An update in cycle M drives the RAM write in cycle M+1, and the RAM commits at the end of M+1.
- Visibility of an update in cycle M:
  - A lookup to the same index in cycle M+1 sees the new value (RAM bypass).
  - A lookup in cycle M sees the old value.
- An update in cycle M+1 to the same index uses the forwarded wr_cnt as base, ignoring upd_cnt_i.
- One update is accepted per cycle; updates and lookups may occur in the same cycle.

## Test plan
- Reset, then a 1024-cycle sweep:
  - ram_a_o walks 0..1023 with ram_d_o = 01 and ram_we_o = 1.
  - ready_o = 1 in cycle 1025.
  - A lookup of PC 0x1000 then gives pred_cnt_o = 01 and pred_taken_o = 0.
- Update PC 0x40 (taken, cnt 01) in cycle M, then lookup 0x40 in cycle M+1 -> ram_a_o = 0x010, ram_d_o = 10, and pred_cnt_o = 10 with pred_taken_o = 1 in M+2.
- Saturation:
  - Update taken with cnt 11 -> write 11.
  - Update not-taken with cnt 00 -> write 00.
- Back-to-back updates to PC 0x80, both taken, both with snapshot 01 -> writes 10 then 11 (forwarded base).
- Back-to-back updates to different indices 0x80 and 0x84 with snapshot 01, taken -> each writes 10 (no forwarding).
- Reset asserted at init_idx = 500, or during a RUN update -> no write of the pending update, and the sweep restarts at index 0 with ready_o = 0.
